// File: rtl/microseq_if.sv
// Controller <-> datapath bundle: microword and status in, decoder index and strobes out.
interface microseq_if #(
  parameter int unsigned WordSize  = 8,
  parameter int unsigned UstepBits = 4,
  parameter int unsigned AluopBits = 5,
  parameter int unsigned LoadBits  = 3,
  parameter int unsigned DbusBits  = 2,
  parameter int unsigned JumpBits  = 3
);
  localparam int unsigned CtrlWidth = AluopBits + LoadBits + DbusBits + JumpBits + 5;

  logic [WordSize-1:0]           databus;
  logic [CtrlWidth-1:0]          uword;
  logic                          alu_c;
  logic                          alu_z;
  logic                          alu_n;
  logic                          alu_v;
  logic                          io_ready;

  logic [WordSize+UstepBits-1:0] uaddr;
  logic [WordSize-1:0]           IRval;
  logic [AluopBits-1:0]          ALUop;
  logic [DbusBits-1:0]           DbusOp;
  logic [2**LoadBits-1:0]        load_n;
  logic                          PCload;
  logic                          PCincr;
  logic                          ARena;
  logic                          stall;
  logic                          ustep_ovf;

  modport master (
    input  databus, uword, alu_c, alu_z, alu_n, alu_v, io_ready,
    output uaddr, IRval, ALUop, DbusOp, load_n, PCload, PCincr, ARena, stall, ustep_ovf
  );

  modport slave (
    output databus, uword, alu_c, alu_z, alu_n, alu_v, io_ready,
    input  uaddr, IRval, ALUop, DbusOp, load_n, PCload, PCincr, ARena, stall, ustep_ovf
  );
endinterface

// File: rtl/microseq_ctrl.sv
// Microsequencer for the CSCvon8 family: IR, microstep counter, latched flags, jump
// evaluation and I/O wait stalls; decodes the ROM microword into active-low strobes.
module microseq_ctrl #(
  parameter int unsigned WordSize  = 8,
  parameter int unsigned UstepBits = 4,
  parameter int unsigned AluopBits = 5,
  parameter int unsigned LoadBits  = 3,
  parameter int unsigned DbusBits  = 2,
  parameter int unsigned JumpBits  = 3
) (
  input logic       clk,
  input logic       reset,
  microseq_if.master bus
);
  localparam int unsigned LoadPos = AluopBits;
  localparam int unsigned DbusPos = LoadPos + LoadBits;
  localparam int unsigned JumpPos = DbusPos + DbusBits;
  localparam int unsigned CtlPos  = JumpPos + JumpBits;

  logic [LoadBits-1:0]  load_op;
  logic [JumpBits-1:0]  jump_op;
  logic                 arena_n;
  logic                 pcincr_n;
  logic                 usreset_n;
  logic                 flag_latch_n;
  logic                 wait_req;

  logic [UstepBits-1:0] step_q, step_d;
  logic [WordSize-1:0]  ir_q, ir_d;
  logic [3:0]           flags_q, flags_d;  // {V,N,Z,C}
  logic                 ovf_q, ovf_d;

  logic                 stall;
  logic [7:0]           cond_vec;
  logic                 jump_take;
  logic [2**LoadBits-1:0] load_n;

  assign load_op      = bus.uword[LoadPos +: LoadBits];
  assign jump_op      = bus.uword[JumpPos +: JumpBits];
  assign arena_n      = bus.uword[CtlPos];
  assign pcincr_n     = bus.uword[CtlPos + 1];
  assign usreset_n    = bus.uword[CtlPos + 2];
  assign flag_latch_n = bus.uword[CtlPos + 3];
  assign wait_req     = bus.uword[CtlPos + 4];

  assign stall = wait_req & ~bus.io_ready;

  // Conditions are evaluated on latched flags only, so a latch in the same word is not seen.
  assign cond_vec  = {1'b1, ~flags_q[1], ~flags_q[0], flags_q[3], flags_q[2], flags_q[1],
                      flags_q[0], 1'b0};
  assign jump_take = cond_vec[jump_op[2:0]];

  always_comb begin
    load_n = '1;
    if (!stall && (load_op != '0)) begin
      load_n[load_op] = 1'b0;
    end
  end

  always_comb begin
    step_d  = step_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    ovf_d   = ovf_q;
    if (!stall) begin
      if (!usreset_n) begin
        step_d = '0;
      end else begin
        step_d = step_q + UstepBits'(1);
        if (step_q == '1) begin
          ovf_d = 1'b1;
        end
      end
      if (!load_n[1]) begin
        ir_d = bus.databus;
      end
      if (!flag_latch_n) begin
        flags_d = {bus.alu_v, bus.alu_n, bus.alu_z, bus.alu_c};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      step_q  <= '0;
      ir_q    <= '0;
      flags_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      step_q  <= step_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.uaddr     = {ir_q, step_q};
  assign bus.IRval     = ir_q;
  assign bus.ALUop     = bus.uword[AluopBits-1:0];
  assign bus.DbusOp    = bus.uword[DbusPos +: DbusBits];
  assign bus.load_n    = load_n;
  assign bus.PCload    = stall | ~jump_take;
  assign bus.PCincr    = stall | pcincr_n;
  assign bus.ARena     = arena_n;
  assign bus.stall     = stall;
  assign bus.ustep_ovf = ovf_q;
endmodule

// File: tb/tb_microseq_ctrl.sv
// Scoreboard bench for microseq_ctrl: default build plus a UstepBits=5 build.
module tb_microseq_ctrl;
  localparam int unsigned CW = 18;

  typedef enum int {
    SelUaddr, SelIr, SelLoadN, SelPcload, SelPcincr, SelArena, SelAluop, SelStall, SelOvf,
    SelUaddr2, SelOvf2
  } sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reset2 = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  microseq_if bus ();
  microseq_if #(.UstepBits(5)) bus2 ();

  microseq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  microseq_ctrl #(.UstepBits(5)) dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  function automatic logic [CW-1:0] mk(input logic [4:0] alu, input logic [2:0] ld,
                                       input logic [1:0] db, input logic [2:0] jmp,
                                       input logic arena_n, input logic pcincr_n,
                                       input logic usr_n, input logic flag_n, input logic wt);
    return {wt, flag_n, usr_n, pcincr_n, arena_n, jmp, db, ld, alu};
  endfunction

  function automatic logic [CW-1:0] nop(input logic [2:0] jmp);
    return mk(5'd0, 3'd0, 2'd0, jmp, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
  endfunction

  function automatic logic [31:0] observe(input sel_e sel);
    case (sel)
      SelUaddr:  return 32'(bus.uaddr);
      SelIr:     return 32'(bus.IRval);
      SelLoadN:  return 32'(bus.load_n);
      SelPcload: return 32'(bus.PCload);
      SelPcincr: return 32'(bus.PCincr);
      SelArena:  return 32'(bus.ARena);
      SelAluop:  return 32'(bus.ALUop);
      SelStall:  return 32'(bus.stall);
      SelOvf:    return 32'(bus.ustep_ovf);
      SelUaddr2: return 32'(bus2.uaddr);
      SelOvf2:   return 32'(bus2.ustep_ovf);
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push_exp(input string tag, input sel_e sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // Compare everything queued for this cycle mid-period, then advance past the next edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  jtab_a [5] = '{3'd2, 3'd6, 3'd7, 3'd0, 3'd1};
  logic        jexp_a [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [2:0]  jtab_b [5] = '{3'd2, 3'd6, 3'd4, 3'd3, 3'd5};
  logic        jexp_b [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    bus.databus = '0; bus.uword = nop(3'd0);
    bus.alu_c = 0; bus.alu_z = 0; bus.alu_n = 0; bus.alu_v = 0; bus.io_ready = 1'b1;
    bus2.databus = '0; bus2.uword = nop(3'd0);
    bus2.alu_c = 0; bus2.alu_z = 0; bus2.alu_n = 0; bus2.alu_v = 0; bus2.io_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;

    push_exp("rst_uaddr", SelUaddr, 32'h000);
    push_exp("rst_ovf", SelOvf, 32'h0);
    push_exp("rst_stall", SelStall, 32'h0);
    push_exp("rst_loadn", SelLoadN, 32'hFF);
    tick();

    // Reset mid-op: IR=0x3C, step=5, flags nonzero
    bus.databus = 8'h3C;
    bus.uword = mk(5'd0, 3'd1, 2'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    push_exp("ir_load_uaddr", SelUaddr, 32'h001);
    push_exp("ir_load_strobe", SelLoadN, 32'hFD);
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.uword = (i == 0) ? mk(5'd0, 3'd0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)
                           : nop(3'd0);
      bus.alu_c = (i == 0); bus.alu_z = (i == 0);
      push_exp("midop_uaddr", SelUaddr, 32'h3C0 + 32'(i));
      tick();
    end
    bus.uword = nop(3'd1);
    push_exp("midop_step5", SelUaddr, 32'h3C5);
    push_exp("midop_jc", SelPcload, 32'h0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    push_exp("reset_uaddr", SelUaddr, 32'h000);
    push_exp("reset_flag_c", SelPcload, 32'h1);
    push_exp("reset_ovf", SelOvf, 32'h0);
    tick();
    bus.uword = nop(3'd6);
    push_exp("reset_flag_nz", SelPcload, 32'h0);
    tick();

    // Fetch 0xA7
    bus.databus = 8'hA7;
    bus.uword = mk(5'd0, 3'd1, 2'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    push_exp("fetch_strobe", SelLoadN, 32'hFD);
    tick();
    bus.databus = 8'h00;
    bus.uword = nop(3'd0);
    push_exp("fetch_a70", SelUaddr, 32'hA70);
    push_exp("fetch_ir", SelIr, 32'hA7);
    tick();
    bus.uword = mk(5'd0, 3'd0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    push_exp("fetch_a71", SelUaddr, 32'hA71);
    tick();
    bus.uword = nop(3'd0);
    push_exp("fetch_back_a70", SelUaddr, 32'hA70);
    tick();

    // Flags: latch Z=1 with a jump in the same word (uses old flags)
    bus.alu_z = 1'b1; bus.alu_c = 1'b0;
    bus.uword = mk(5'd0, 3'd0, 2'd0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push_exp("latch_jz_old", SelPcload, 32'h1);
    tick();
    bus.alu_z = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.uword = nop(jtab_a[i]);
      push_exp($sformatf("z1_jump%0d", jtab_a[i]), SelPcload, 32'(jexp_a[i]));
      tick();
    end
    bus.alu_v = 1'b1;
    bus.uword = mk(5'd0, 3'd0, 2'd0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push_exp("latch2_jz_old", SelPcload, 32'h0);
    tick();
    bus.alu_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.uword = nop(jtab_b[i]);
      push_exp($sformatf("v1_jump%0d", jtab_b[i]), SelPcload, 32'(jexp_b[i]));
      tick();
    end

    // Stall on I/O wait
    bus.uword = mk(5'd0, 3'd0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    bus.io_ready = 1'b0;
    bus.uword = mk(5'h15, 3'd7, 2'd2, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      push_exp("stall_flag", SelStall, 32'h1);
      push_exp("stall_loadn", SelLoadN, 32'hFF);
      push_exp("stall_pcincr", SelPcincr, 32'h1);
      push_exp("stall_pcload", SelPcload, 32'h1);
      push_exp("stall_arena", SelArena, 32'h0);
      push_exp("stall_aluop", SelAluop, 32'h15);
      push_exp("stall_uaddr", SelUaddr, 32'hA70);
      tick();
    end
    bus.io_ready = 1'b1;
    push_exp("ready_stall", SelStall, 32'h0);
    push_exp("ready_loadn", SelLoadN, 32'h7F);
    push_exp("ready_pcincr", SelPcincr, 32'h0);
    push_exp("ready_pcload", SelPcload, 32'h0);
    tick();
    bus.uword = nop(3'd0);
    push_exp("ready_step", SelUaddr, 32'hA71);
    tick();
    bus.io_ready = 1'b0;
    bus.databus = 8'h55;
    bus.uword = mk(5'd0, 3'd1, 2'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    push_exp("stall_irload_strobe", SelLoadN, 32'hFF);
    tick();
    bus.io_ready = 1'b1;
    bus.uword = nop(3'd0);
    push_exp("stall_ir_hold", SelIr, 32'hA7);
    push_exp("stall_step_hold", SelUaddr, 32'hA72);
    tick();

    // Step counter wrap
    bus.uword = mk(5'd0, 3'd0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    bus.uword = nop(3'd0);
    for (int i = 0; i < 16; i++) begin
      push_exp("wrap_uaddr", SelUaddr, 32'hA70 + 32'(i));
      push_exp("wrap_ovf_clear", SelOvf, 32'h0);
      tick();
    end
    push_exp("wrap_to_zero", SelUaddr, 32'hA70);
    push_exp("wrap_ovf_set", SelOvf, 32'h1);
    tick();
    bus.uword = mk(5'd0, 3'd0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    push_exp("ovf_sticky_usr", SelOvf, 32'h1);
    tick();
    bus.uword = nop(3'd0);
    push_exp("ovf_sticky", SelOvf, 32'h1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    push_exp("ovf_reset", SelOvf, 32'h0);
    push_exp("ovf_reset_uaddr", SelUaddr, 32'h000);
    tick();

    // Wider step counter build
    reset2 = 1'b1;
    bus2.databus = 8'h81;
    bus2.uword = mk(5'd0, 3'd1, 2'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    push_exp("w5_rst_uaddr", SelUaddr2, 32'h0000);
    tick();
    bus2.uword = nop(3'd0);
    for (int i = 0; i < 32; i++) begin
      push_exp("w5_uaddr", SelUaddr2, 32'h1020 + 32'(i));
      push_exp("w5_ovf_clear", SelOvf2, 32'h0);
      tick();
    end
    push_exp("w5_wrap", SelUaddr2, 32'h1020);
    push_exp("w5_ovf_set", SelOvf2, 32'h1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
